// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the OTTER MMIO UART transmitter: bus addresses,
// default timing and the transmit FSM state encoding.
package uart_tx_fifo_pkg;

  localparam logic [31:0] UART_DATA_AD     = 32'h1118_0000;
  localparam logic [31:0] UART_RDY_AD      = 32'h111C_0000;
  localparam int unsigned DEF_CLKS_PER_BIT = 868;
  localparam int unsigned DEF_FIFO_DEPTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

  // Line level driven while the FSM sits in a given state.
  function automatic logic tx_level(input uart_tx_state_t st, input logic shift_lsb);
    case (st)
      ST_START: tx_level = 1'b0;
      ST_DATA:  tx_level = shift_lsb;
      default:  tx_level = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered read data, updated on each accepted pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_rdata;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally; count disambiguates full from empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rdata  <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// MMIO UART transmitter: bytes written by the CPU queue in a FIFO and are
// serialised as 8N1 frames; READY lets software poll instead of stalling.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter  int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR,
  input  logic [7:0]    DATA,
  input  logic          CLR_OVF,
  output logic          READY,
  output logic          FULL,
  output logic          EMPTY,
  output logic [CW-1:0] COUNT,
  output logic          BUSY,
  output logic          OVF,
  output logic          TX
);

  localparam int unsigned BCW = $clog2(CLKS_PER_BIT);

  uart_tx_state_t r_state;
  uart_tx_state_t w_state_nxt;
  logic [BCW-1:0] r_bcnt;
  logic [BCW-1:0] w_bcnt_nxt;
  logic [2:0]     r_idx;
  logic [2:0]     w_idx_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_tx;
  logic           r_busy;
  logic           r_ovf;
  logic           w_bit_end;
  logic           w_pop;
  logic           w_ovf_set;
  logic [7:0]     w_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (WR),
    .i_wdata (DATA),
    .i_pop   (w_pop),
    .o_full  (FULL),
    .o_empty (EMPTY),
    .o_count (COUNT),
    .o_rdata (w_rdata)
  );

  assign READY     = !FULL;
  assign TX        = r_tx;
  assign BUSY      = r_busy;
  assign OVF       = r_ovf;
  assign w_bit_end = (r_bcnt == BCW'(CLKS_PER_BIT - 1));
  assign w_ovf_set = WR && FULL && !w_pop;

  // Next-state logic; popped byte is latched into the shift register at the
  // end of START, by which time the FIFO read register holds it.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = w_bit_end ? '0 : r_bcnt + BCW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bcnt_nxt = '0;
        if (!EMPTY) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = 3'd0;
          w_shift_nxt = w_rdata;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (!EMPTY) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // TX is driven from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= tx_level(r_state, r_shift[0]);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (CLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule
